// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell walks WIDTH-bit operands LSB first,
// with a start/busy/done handshake framing each operation.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] a_sr_reg, b_sr_reg, sum_sr_reg, sum_reg;
    logic             carry_reg, cout_reg, ovf_reg;

    logic             accept;
    logic             last_bit;
    logic             fa_s, fa_co;
    logic [WIDTH-1:0] sum_sr_next;

    assign last_bit    = (cnt_reg == CW'(WIDTH - 1));
    assign fa_s        = a_sr_reg[0] ^ b_sr_reg[0] ^ carry_reg;
    assign fa_co       = ((a_sr_reg[0] ^ b_sr_reg[0]) & carry_reg) | (a_sr_reg[0] & b_sr_reg[0]);
    assign sum_sr_next = {fa_s, sum_sr_reg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: invert B on load and force the initial carry high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            a_sr_reg   <= '0;
            b_sr_reg   <= '0;
            sum_sr_reg <= '0;
            sum_reg    <= '0;
            carry_reg  <= 1'b0;
            cout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else if (accept) begin
            cnt_reg   <= '0;
            a_sr_reg  <= a;
            b_sr_reg  <= sub ? ~b : b;
            carry_reg <= sub ? 1'b1 : cin;
        end else if (state_reg == RUN) begin
            cnt_reg    <= cnt_reg + 1'b1;
            a_sr_reg   <= {1'b0, a_sr_reg[WIDTH-1:1]};
            b_sr_reg   <= {1'b0, b_sr_reg[WIDTH-1:1]};
            sum_sr_reg <= sum_sr_next;
            carry_reg  <= fa_co;
            if (last_bit) begin
                // carry_reg here is the carry into the MSB cell.
                sum_reg  <= sum_sr_next;
                cout_reg <= fa_co;
                ovf_reg  <= carry_reg ^ fa_co;
            end
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8) with hand-computed expected results.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int checks   = 0;
    int failures = 0;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-16s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Tick until done rises; returns ticks taken and how many of them had busy high beforehand.
    task automatic wait_done(output int ticks, output int busy_cnt);
        ticks    = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && ticks < 40) begin
            if (busy === 1'b1) busy_cnt++;
            tick();
            ticks++;
        end
    endtask

    task automatic run_op(input string tag, input logic s, input logic [7:0] av,
                          input logic [7:0] bv, input logic c, input logic [7:0] exp_sum,
                          input logic exp_cout, input logic exp_ovf);
        int t, bc;
        sub = s; a = av; b = bv; cin = c; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(t, bc);
        $display("op %s sub=%0d a=0x%02h b=0x%02h cin=%0d -> sum=0x%02h cout=%0d ovf=%0d",
                 tag, s, av, bv, c, sum, cout, ovf);
        check({tag, "_lat"},  t,    8);
        check({tag, "_busy"}, bc,   8);
        check({tag, "_done"}, done, 1);
        check({tag, "_sum"},  sum,  exp_sum);
        check({tag, "_cout"}, cout, exp_cout);
        check({tag, "_ovf"},  ovf,  exp_ovf);
        tick();
        check({tag, "_pulse"}, done, 0);
    endtask

    initial begin
        int t, bc, seen;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum",  sum,  0);
        check("rst_cout", cout, 0);
        check("rst_ovf",  ovf,  0);
        rst_n = 1'b1;
        tick();

        run_op("add5a3c", 1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b1 ^ 1'b1, 1'b1);
        run_op("addwrap", 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("addcin",  1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        run_op("sub1020", 1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0);
        run_op("sub8001", 1'b1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

        // start pulsed during RUN with other operands must not disturb the op in flight
        sub = 1'b0; a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; tick();
        start = 1'b1; a = 8'hFF; b = 8'hFF; sub = 1'b1; tick();
        start = 1'b0; tick();
        wait_done(t, bc);
        check("ign_lat", t + 3, 8);
        check("ign_sum", sum, 8'h33);
        tick();

        // back-to-back with start held high
        sub = 1'b0; a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        tick();
        a = 8'h7F; b = 8'h01;
        wait_done(t, bc);
        check("b2b_sum0", sum, 8'h03);
        check("b2b_lat0", t, 8);
        tick();
        t = 1;
        while (done !== 1'b1 && t < 40) begin
            tick();
            t++;
        end
        start = 1'b0;
        $display("b2b second result sum=0x%02h cout=%0d ovf=%0d spacing=%0d", sum, cout, ovf, t);
        check("b2b_space", t, 9);
        check("b2b_sum1", sum, 8'h80);
        check("b2b_cout1", cout, 0);
        check("b2b_ovf1", ovf, 1);
        tick();
        check("b2b_idle", done | busy, 0);

        // reset on the 4th RUN cycle
        sub = 1'b0; a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mr_busy", busy, 0);
        check("mr_done", done, 0);
        check("mr_sum",  sum,  0);
        check("mr_cout", cout, 0);
        check("mr_ovf",  ovf,  0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        check("mr_nodone", seen, 0);

        // hold after done with noisy inputs and no start
        run_op("hold", 1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            cin = 1'($urandom);
            sub = 1'($urandom);
            tick();
            check("hold_sum",  sum,  8'h96);
            check("hold_done", done, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial add/subtract controller. It sequences one internal 1-bit full-adder cell over WIDTH-bit operands, LSB first, and holds the running carry in a register. A start/busy/done handshake frames each operation. It is the area-minimal alternative to a ripple-carry array and is used wherever throughput of one result per WIDTH+1 cycles is enough.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
start  input  1  request a new operation; sampled only in IDLE or DONE
sub  input  1  0 = add, 1 = subtract (a - b); captured with start
a  input  WIDTH  operand A; captured with start
b  input  WIDTH  operand B; captured with start
cin  input  1  carry-in for add; ignored when sub = 1
busy  output  1  high while in RUN
done  output  1  single-cycle pulse when the result becomes valid
sum  output  WIDTH  result; held stable from done until the next accepted start
cout  output  1  final carry out (for subtract: 1 = no borrow)
ovf  output  1  two's-complement overflow flag

Behaviour:
- One clock domain (clk). Reset is synchronous and active-low: rst_n sampled low at a rising edge forces the following:
  - state = IDLE
  - busy = 0, done = 0
  - sum = 0, cout = 0, ovf = 0
  - bit counter = 0, carry register = 0
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN. Otherwise stay in IDLE.
  - RUN --counter == WIDTH-1--> DONE. Otherwise stay in RUN and increment the counter.
  - DONE --start--> RUN (back-to-back operation). Otherwise go to IDLE.
- Actions on an accepted start (edge E0):
  - Load A shift register with a.
  - Load B shift register with b when sub = 0, or with ~b when sub = 1.
  - Carry register = cin when sub = 0, or 1 when sub = 1.
  - Counter = 0. Latch sub.
  - sum, cout and ovf keep their old values until DONE.
- Each RUN cycle:
  - The full-adder cell computes s = a0 ^ b0 ^ c and co = ((a0 ^ b0) & c) | (a0 & b0), where a0 and b0 are the shift-register LSBs and c is the carry register.
  - s is shifted into the MSB of the sum shift register; the operand registers shift right.
  - The carry register takes co.
  - On the counter == WIDTH-1 cycle, the carry into that cycle is also latched as c_msb_in.
- Entering DONE (edge E0+WIDTH):
  - sum = sum shift register.
  - cout = final carry.
  - ovf = c_msb_in ^ final carry.
  - done = 1 for exactly that one cycle.
- Latency: start sampled at E0 → busy is high for cycles E0+1 .. E0+WIDTH → done is high in the cycle after edge E0+WIDTH. One result per WIDTH+1 cycles when start is held high.
- start during RUN is ignored; the operation in flight is not disturbed, and inputs may change freely while busy.
- start and a sub change in the same cycle: the sub value present with start is used.
- Reset asserted mid-RUN: the operation is abandoned and all outputs reach their reset values on that edge. No done pulse is produced for the abandoned operation.
- Width rules:
  - Result is modulo 2^WIDTH; cout is the carry out of bit WIDTH-1.
  - In subtract mode, cout = 1 means a >= b (unsigned).
  - ovf is meaningful for signed interpretation only.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. WIDTH=8, add: a=0x5A, b=0x3C, cin=0, start pulsed at E0 → busy high for 8 cycles, done at E0+8: sum=0x96, cout=0, ovf=1.
2. Add with wrap-around: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. Repeat with a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1.
3. Subtract: sub=1, a=0x10, b=0x20 → sum=0xF0, cout=0, ovf=0. Then sub=1, a=0x80, b=0x01 → sum=0x7F, cout=1, ovf=1.
4. start held high continuously with operand pairs (0x01,0x02), (0x7F,0x01) → done pulses exactly 9 cycles apart, sum=0x03 then 0x80 (ovf=1). Pulses of start during RUN cause no change.
5. Reset mid-op: start (a=0xAA, b=0x55), rst_n low on the 4th RUN cycle → next cycle busy=0, done=0, sum=0, cout=0, ovf=0, state IDLE. No done pulse follows until a new start.
6. Hold after done: after scenario 1, randomise a, b and cin for 20 cycles without start → sum stays 0x96, done stays 0.
